// File: rtl/xdma_pkg.sv
// Shared constants and state encoding for the XDMA card-to-host stream path.
package xdma_pkg;

   localparam int          BEAT_WIDTH = 512;
   localparam int          KEEP_WIDTH = 64;
   localparam logic [15:0] HDR_MAGIC  = 16'hD1F7;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } c2h_state_e;

endpackage

// File: rtl/xdma_c2h_tx.sv
// Splits one DiffTest batch packet into 512-bit AXI-Stream beats towards the host DMA.
// Optional XDMA_C2H_SEQ_HDR_EN prepends a header beat carrying a packet sequence number.
//
// state | meaning
// IDLE  | no packet held, ready to accept
// SEND  | packet held, beats pending on the stream
module xdma_c2h_tx
   import xdma_pkg::*;
#(
   parameter int IN_WIDTH = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_data,
   output logic                  core_clock_enable,
   output logic                  axi_c2h_tvalid,
   input  logic                  axi_c2h_tready,
   output logic [BEAT_WIDTH-1:0] axi_c2h_tdata,
   output logic [KEEP_WIDTH-1:0] axi_c2h_tkeep,
   output logic                  axi_c2h_tlast
);

   localparam int NBEATS = IN_WIDTH / BEAT_WIDTH;
`ifdef XDMA_C2H_SEQ_HDR_EN
   localparam int HDR_BEATS = 1;
`else
   localparam int HDR_BEATS = 0;
`endif
   localparam int               CNT_W    = $clog2(NBEATS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1 + HDR_BEATS);

   if (IN_WIDTH <= 0 || (IN_WIDTH % BEAT_WIDTH) != 0) begin : g_bad_width
      $error("xdma_c2h_tx: IN_WIDTH must be a positive multiple of 512");
   end

   c2h_state_e            state_q;
   c2h_state_e            state_d;
   logic [CNT_W-1:0]      beat_q;
   logic [IN_WIDTH-1:0]   pkt_q;
   logic [BEAT_WIDTH-1:0] beat_data;
   logic                  fire;
   logic                  last_beat;
   logic                  done;
   logic                  accept;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // in_ready is gated by reset so nothing is advertised while reset is held
   always_comb begin
      state_d        = state_q;
      axi_c2h_tvalid = (state_q == SEND);
      fire           = axi_c2h_tvalid && axi_c2h_tready;
      last_beat      = (beat_q == LAST_IDX);
      done           = fire && last_beat;
      in_ready       = reset && ((state_q == IDLE) || done);
      accept         = in_valid && in_ready;
      if (accept) begin
         state_d = SEND;
      end else if (done) begin
         state_d = IDLE;
      end
   end

   assign core_clock_enable = in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat_q <= '0;
         pkt_q  <= '0;
      end else begin
         if (accept) begin
            pkt_q <= in_data;
         end
         if (done) begin
            beat_q <= '0;
         end else if (fire) begin
            beat_q <= beat_q + 1'b1;
         end
      end
   end

`ifdef XDMA_C2H_SEQ_HDR_EN
   logic [31:0] seq_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seq_q <= '0;
      end else if (done) begin
         seq_q <= seq_q + 32'd1;
      end
   end
`endif

   always_comb begin
      beat_data = '0;
      for (int k = 0; k < NBEATS; k++) begin
         if (int'(beat_q) == k + HDR_BEATS) begin
            beat_data = pkt_q[k*BEAT_WIDTH +: BEAT_WIDTH];
         end
      end
`ifdef XDMA_C2H_SEQ_HDR_EN
      if (beat_q == '0) begin
         beat_data = {{(BEAT_WIDTH-64){1'b0}}, HDR_MAGIC, 16'(NBEATS), seq_q};
      end
`endif
   end

   assign axi_c2h_tdata = axi_c2h_tvalid ? beat_data : '0;
   assign axi_c2h_tkeep = axi_c2h_tvalid ? '1 : '0;
   assign axi_c2h_tlast = axi_c2h_tvalid && last_beat;

endmodule

// File: tb/tb_xdma_c2h_tx.sv
// Self-checking bench for xdma_c2h_tx with IN_WIDTH=1024 (two data beats per packet).
module tb_xdma_c2h_tx;

   localparam int IN_WIDTH = 1024;
`ifdef XDMA_C2H_SEQ_HDR_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [IN_WIDTH-1:0] in_data = '0;
   logic                core_clock_enable;
   logic                axi_c2h_tvalid;
   logic                axi_c2h_tready = 1'b1;
   logic [511:0]        axi_c2h_tdata;
   logic [63:0]         axi_c2h_tkeep;
   logic                axi_c2h_tlast;

   typedef struct packed {
      logic [511:0] data;
      logic         last;
   } beat_t;

   typedef struct {
      logic [IN_WIDTH-1:0] data;
      int                  stall;
   } vec_t;

   beat_t        exp_q[$];
   beat_t        exp_b;
   int           total = 0;
   int           bad = 0;
   logic [31:0]  seq_model = '0;
   logic         prev_stall = 1'b0;
   logic [511:0] prev_data = '0;
   logic         prev_last = 1'b0;

   xdma_c2h_tx #(.IN_WIDTH(IN_WIDTH)) dut (
      .clock             (clock),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .core_clock_enable (core_clock_enable),
      .axi_c2h_tvalid    (axi_c2h_tvalid),
      .axi_c2h_tready    (axi_c2h_tready),
      .axi_c2h_tdata     (axi_c2h_tdata),
      .axi_c2h_tkeep     (axi_c2h_tkeep),
      .axi_c2h_tlast     (axi_c2h_tlast)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [IN_WIDTH-1:0] rand_pkt();
      logic [IN_WIDTH-1:0] d;
      for (int i = 0; i < IN_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic void push_pkt(input logic [IN_WIDTH-1:0] d);
      beat_t b;
      if (HDR != 0) begin
         b.data         = '0;
         b.data[31:0]   = seq_model;
         b.data[47:32]  = 16'd2;
         b.data[63:48]  = 16'hD1F7;
         b.last         = 1'b0;
         exp_q.push_back(b);
         seq_model      = seq_model + 32'd1;
      end
      b.data = d[511:0];
      b.last = 1'b0;
      exp_q.push_back(b);
      b.data = d[1023:512];
      b.last = 1'b1;
      exp_q.push_back(b);
   endfunction

   // Scoreboard: expected beats queued at packet acceptance, popped on each handshake.
   always @(negedge clock) begin
      if (!reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", axi_c2h_tvalid, 1'b1);
            check("hold_data", axi_c2h_tdata, prev_data);
            check("hold_last", axi_c2h_tlast, prev_last);
         end
         check("cce_eq_ready", core_clock_enable, in_ready);
         if (!axi_c2h_tvalid) check("tkeep_idle", axi_c2h_tkeep, 64'h0);
         if (axi_c2h_tvalid && axi_c2h_tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h want no beat", axi_c2h_tdata);
            end else begin
               exp_b = exp_q.pop_front();
               check("beat_data", axi_c2h_tdata, exp_b.data);
               check("beat_last", axi_c2h_tlast, exp_b.last);
               check("beat_keep", axi_c2h_tkeep, {64{1'b1}});
            end
         end
         if (in_valid && in_ready) push_pkt(in_data);
         prev_stall <= axi_c2h_tvalid && !axi_c2h_tready;
         prev_data  <= axi_c2h_tdata;
         prev_last  <= axi_c2h_tlast;
      end
   end

   task automatic send_pkt(input logic [IN_WIDTH-1:0] d, input int stall);
      int t;
      t        = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && t < 20) begin
         @(posedge clock); #1;
         t++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1 within 20 cycles");
         in_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (stall > 0) begin
         axi_c2h_tready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_tvalid", axi_c2h_tvalid, 1'b1);
            @(posedge clock); #1;
         end
         axi_c2h_tready = 1'b1;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge clock); #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d beats pending want 0", exp_q.size());
      end
      @(posedge clock); #1;
      check("drain_idle_tvalid", axi_c2h_tvalid, 1'b0);
      check("drain_idle_ready", in_ready, 1'b1);
   endtask

   initial begin
      vec_t                vecs[5];
      logic [IN_WIDTH-1:0] pa;
      logic [IN_WIDTH-1:0] b2b[3];
      int                  t;

      vecs[0] = '{rand_pkt(), 0};
      vecs[1] = '{{IN_WIDTH{1'b1}}, 1};
      vecs[2] = '{rand_pkt(), 3};
      vecs[3] = '{{{512{1'b0}}, {512{1'b1}}}, 2};
      vecs[4] = '{rand_pkt(), 0};

      repeat (2) @(posedge clock);
      #2;
      check("rst_tvalid", axi_c2h_tvalid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_cce", core_clock_enable, 1'b0);
      check("rst_tkeep", axi_c2h_tkeep, 64'h0);
      check("rst_tdata", axi_c2h_tdata, 512'h0);
      check("rst_tlast", axi_c2h_tlast, 1'b0);

      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1'b1);
      check("rel_tvalid", axi_c2h_tvalid, 1'b0);
      check("rel_tkeep", axi_c2h_tkeep, 64'h0);

`ifndef XDMA_C2H_SEQ_HDR_EN
      pa       = rand_pkt();
      in_data  = pa;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      check("lat_b0_valid", axi_c2h_tvalid, 1'b1);
      check("lat_b0_data", axi_c2h_tdata, pa[511:0]);
      check("lat_b0_last", axi_c2h_tlast, 1'b0);
      check("lat_b0_ready", in_ready, 1'b0);
      @(posedge clock); #1;
      check("lat_b1_data", axi_c2h_tdata, pa[1023:512]);
      check("lat_b1_last", axi_c2h_tlast, 1'b1);
      check("lat_b1_ready", in_ready, 1'b1);
      @(posedge clock); #1;
      check("lat_idle_tvalid", axi_c2h_tvalid, 1'b0);
`endif
      drain();

      for (int i = 0; i < 5; i++) begin
         send_pkt(vecs[i].data, vecs[i].stall);
         drain();
      end

      for (int k = 0; k < 3; k++) b2b[k] = rand_pkt();
      for (int k = 0; k < 3; k++) begin
         t        = 0;
         in_data  = b2b[k];
         in_valid = 1'b1;
         while (!in_ready && t < 20) begin
            @(posedge clock); #1;
            t++;
            if (k > 0) check("b2b_no_bubble", axi_c2h_tvalid, 1'b1);
         end
         check("b2b_wait", t, (k == 0) ? 0 : 1 + HDR);
         @(posedge clock); #1;
         check("b2b_valid", axi_c2h_tvalid, 1'b1);
      end
      in_valid = 1'b0;
      drain();

      pa       = rand_pkt();
      in_data  = pa;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      check("mr_pre_valid", axi_c2h_tvalid, 1'b1);
      reset = 1'b0;
      #1;
      check("mr_tvalid", axi_c2h_tvalid, 1'b0);
      check("mr_in_ready", in_ready, 1'b0);
      check("mr_tdata", axi_c2h_tdata, 512'h0);
      check("mr_tlast", axi_c2h_tlast, 1'b0);
      check("mr_tkeep", axi_c2h_tkeep, 64'h0);
      exp_q.delete();
      seq_model = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("mr_rel_ready", in_ready, 1'b1);
      check("mr_rel_tvalid", axi_c2h_tvalid, 1'b0);
      send_pkt(rand_pkt(), 0);
      drain();
      send_pkt(rand_pkt(), 1);
      drain();

      check("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/xdma_c2h_tx.md
XDMA_C2H_TX -- requirements
Module: xdma_c2h_tx

Interface
REQ-001 SHALL provide parameter IN_WIDTH, default 1024, meaning the width of one DiffTest batch packet in bits.
REQ-002 SHALL provide derived constant NBEATS = IN_WIDTH/512, meaning the number of data beats per packet.
REQ-003 SHALL have port clock  input  1  meaning the single clock for all logic.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning a batch packet is offered.
REQ-006 SHALL have port in_ready  output  1  meaning the packet is accepted this cycle.
REQ-007 SHALL have port in_data  input  IN_WIDTH  meaning the batch packet payload.
REQ-008 SHALL have port core_clock_enable  output  1  meaning the core may advance; it equals in_ready.
REQ-009 SHALL have port axi_c2h_tvalid  output  1  meaning the AXI-Stream beat is valid.
REQ-010 SHALL have port axi_c2h_tready  input  1  meaning the host DMA accepts the beat.
REQ-011 SHALL have port axi_c2h_tdata  output  512  meaning the beat data.
REQ-012 SHALL have port axi_c2h_tkeep  output  64  meaning the byte enables; constant all-ones while tvalid is high, otherwise 0.
REQ-013 SHALL have port axi_c2h_tlast  output  1  meaning the final beat of a packet.

Function
REQ-014 SHALL implement states IDLE (no packet held) and SEND (packet held, beats pending).
REQ-015 SHALL drive in_ready high in IDLE, or in SEND when the final beat is handshaken in the same cycle; otherwise in_ready SHALL be low.
REQ-016 SHALL, on in_valid && in_ready, capture in_data and enter or remain in SEND, with beat 0 presented on the next cycle (1-cycle latency).
REQ-017 SHALL present beat k as in_data[512k+511:512k], for k = 0..NBEATS-1 in ascending order.
REQ-018 SHALL advance the beat counter only on tvalid && tready.
REQ-019 SHALL hold tdata, tlast and tkeep stable while tvalid && !tready.
REQ-020 SHALL never deassert tvalid without a handshake.
REQ-021 SHALL assert tlast only on the final beat of each packet.
REQ-022 SHALL return to IDLE after the final handshake when no new packet is captured.
REQ-023 SHALL sustain back-to-back packets with no idle cycle on tvalid when in_valid is held high and tready is held high.
REQ-024 SHALL, when NBEATS=1, assert tlast on every beat and SHALL still accept a new packet in the same cycle as the handshake.
REQ-025 SHALL size the beat counter as $clog2(NBEATS+1) bits and wrap it to 0 at packet end.
REQ-026 SHALL fail elaboration if IN_WIDTH is 0 or not a multiple of 512.

Reset
REQ-027 SHALL, while reset is low, force state=IDLE, beat counter=0, tvalid=0, tlast=0, tdata=0, tkeep=0, in_ready=0, core_clock_enable=0, and sequence counter=0.
REQ-028 SHALL, on reset mid-packet, drop the held packet immediately (asynchronously); the packet SHALL NOT be resent after release.
REQ-029 SHALL drive in_ready high in the first cycle after reset release.

Configuration
REQ-030 SHALL, with macro XDMA_C2H_SEQ_HDR_EN defined, send one header beat before the data beats of each packet: [31:0] packet sequence number, [47:32] NBEATS, [63:48] 16'hD1F7, remaining bits 0.
REQ-031 SHALL, with XDMA_C2H_SEQ_HDR_EN defined, increment the 32-bit sequence number on each packet's final handshake, wrapping at 2^32, with packets totalling NBEATS+1 beats.
REQ-032 SHALL, without XDMA_C2H_SEQ_HDR_EN, contain no header logic and no sequence counter.

Structure
REQ-033 SHALL take BEAT_WIDTH=512, KEEP_WIDTH=64, HDR_MAGIC=16'hD1F7 and the state enum from shared package xdma_pkg.
REQ-034 SHALL be a single module with no sub-module.

Verification (IN_WIDTH=1024, tready high unless stated)
REQ-035 SHALL verify: release reset with in_valid low -> tvalid=0, in_ready=1, tkeep=0.
REQ-036 SHALL verify: one packet {B,A} accepted at cycle N -> beat A at N+1 with tlast=0, beat B at N+2 with tlast=1, IDLE at N+3.
REQ-037 SHALL verify: tready low for 3 cycles on beat 0 -> beat 0 held stable for 4 cycles, in_ready=0, beat 1 follows.
REQ-038 SHALL verify: in_valid held high for 3 packets -> 6 consecutive valid beats, tlast on beats 2, 4 and 6, no bubble.
REQ-039 SHALL verify: reset pulsed low during beat 1 -> tvalid=0 immediately, and the next packet starts at beat 0.
REQ-040 SHALL verify: with XDMA_C2H_SEQ_HDR_EN, two packets -> header beats carrying seq 0 then 1, [47:32]=2, magic 16'hD1F7, 3 beats per packet.
